// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned FETCH_ILEN = 4;

   typedef logic [XLEN-1:0] rvword_t;

   // One fetched instruction together with the byte PC it came from.
   typedef struct packed {
      rvword_t pc;
      rvword_t inst;
   } fetch_pkt_t;

   // Clears the byte-offset bits so the PC lands on an instruction boundary.
   function automatic rvword_t align_pc(input rvword_t pc);
      return pc & ~rvword_t'(FETCH_ILEN - 1);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bundle: instruction memory port, redirect port and decode handshake.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   rvword_t imem_addr;
   rvword_t imem_rdata;
   logic    redirect_valid;
   rvword_t redirect_pc;
   logic    redirect_misal;
   logic    out_valid;
   logic    out_ready;
   rvword_t out_inst;
   rvword_t out_pc;

   // Fetch unit side.
   modport master (
      output imem_addr,
      output redirect_misal,
      output out_valid,
      output out_inst,
      output out_pc,
      input  imem_rdata,
      input  redirect_valid,
      input  redirect_pc,
      input  out_ready
   );

   // Environment side: memory, branch unit and decode.
   modport slave (
      input  imem_addr,
      input  redirect_misal,
      input  out_valid,
      input  out_inst,
      input  out_pc,
      output imem_rdata,
      output redirect_valid,
      output redirect_pc,
      output out_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular buffer between the fetch pipeline and decode.
// DEPTH must be a power of two so the pointers wrap without extra logic.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter type         T     = fetch_pkt_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  T                       push_data,
   input  logic                   pop,
   output T                       head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   T              mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   // Flush overrides both sides; popping an empty buffer is ignored.
   assign do_push = push & ~flush;
   assign do_pop  = pop & ~flush & (count != '0);
   assign head    = mem[rd_ptr];

   // Entry storage; cleared on reset so the head reads as zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem <= '{default: '0};
      end else if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Read/write pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // A push into a full buffer without a matching pop would drop a fetched word.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
      !(do_push && !do_pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives a 1-cycle-latency instruction
// memory and hands {pc, inst} pairs to decode through a small buffer.
// RESET_PC must be word aligned; FIFO_DEPTH must be a power of two and >= 2.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter rvword_t     RESET_PC   = 32'h0,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   rvword_t       fetch_pc;
   rvword_t       inflight_pc_q;
   logic          inflight_q;
   logic          misal_q;
   logic [CW-1:0] fifo_count;
   fetch_pkt_t    head;
   fetch_pkt_t    push_data;
   logic          pop_c;
   logic          push_c;
   logic          issue_c;
   logic [31:0]   occupancy_c;

   // Decode handshake and buffer-space accounting. A request is only issued when
   // its response is guaranteed a slot, since the memory cannot be stalled.
   assign pop_c       = bus.out_valid & bus.out_ready;
   assign push_c      = inflight_q;
   assign occupancy_c = 32'(fifo_count) - 32'(pop_c) + 32'(inflight_q);
   assign issue_c     = ~bus.redirect_valid & (occupancy_c < FIFO_DEPTH);

   assign push_data.pc   = inflight_pc_q;
   assign push_data.inst = bus.imem_rdata;

   assign bus.imem_addr      = fetch_pc >> 2;
   assign bus.out_valid      = (fifo_count != '0);
   assign bus.out_pc         = head.pc;
   assign bus.out_inst       = head.inst;
   assign bus.redirect_misal = misal_q;

   // Fetch PC and in-flight tracking; a redirect wins over a normal issue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc      <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else if (bus.redirect_valid) begin
         fetch_pc   <= align_pc(bus.redirect_pc);
         inflight_q <= 1'b0;
      end else if (issue_c) begin
         fetch_pc      <= fetch_pc + rvword_t'(FETCH_ILEN);
         inflight_q    <= 1'b1;
         inflight_pc_q <= fetch_pc;
      end else begin
         inflight_q <= 1'b0;
      end
   end

   // One-cycle flag for a redirect target that was not word aligned.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misal_q <= 1'b0;
      end else begin
         misal_q <= bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (fetch_pkt_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.redirect_valid),
      .push      (push_c),
      .push_data (push_data),
      .pop       (pop_c),
      .head      (head),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a random phase,
// all deliveries checked against an in-order expected-PC stream model.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic    clk = 1'b0;
   logic    rst = 1'b0;
   int      checks = 0;
   int      failures = 0;
   int      idle = 0;
   int      delivered = 0;
   rvword_t exp_pc = '0;

   fetch_unit_if bus();

   fetch_unit #(
      .RESET_PC   (32'h0),
      .FIFO_DEPTH (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory contents: word address a holds 0x1000_0000 + a.
   function automatic rvword_t mem_word(input rvword_t waddr);
      return 32'h1000_0000 + waddr;
   endfunction

   // Synchronous instruction memory with one cycle of read latency.
   always @(posedge clk) bus.imem_rdata <= mem_word(bus.imem_addr);

   task automatic check(input string tag, input rvword_t obs, input rvword_t exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, score any handshake against the expected stream,
   // advance, then check the per-cycle rules.
   task automatic cycle(input logic rdy, input logic rv, input rvword_t rpc);
      logic    held;
      logic    exp_misal;
      rvword_t hpc;
      rvword_t hinst;
      bus.out_ready      = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      held      = bus.out_valid && !rdy && !rv;
      hpc       = bus.out_pc;
      hinst     = bus.out_inst;
      exp_misal = rv && (rpc[1:0] != 2'b00);
      if (bus.out_valid && rdy) begin
         check("deliver_pc", bus.out_pc, exp_pc);
         check("deliver_inst", bus.out_inst, mem_word(exp_pc >> 2));
         exp_pc = exp_pc + 32'(FETCH_ILEN);
         delivered++;
         idle = 0;
      end else if (rdy && !rv) begin
         idle++;
      end else begin
         idle = 0;
      end
      if (rv) begin
         exp_pc = rpc & ~32'h3;
         idle   = 0;
      end
      @(posedge clk);
      #1;
      bus.redirect_valid = 1'b0;
      check("misal_pulse", 32'(bus.redirect_misal), 32'(exp_misal));
      if (rv) check("valid_drop_after_redirect", 32'(bus.out_valid), 32'd0);
      if (held) begin
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_pc", bus.out_pc, hpc);
         check("hold_inst", bus.out_inst, hinst);
      end
      check("starve_bound", 32'(idle > 3), 32'd0);
   endtask

   initial begin
      rvword_t addr_snap;
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", 32'(bus.out_valid), 32'd0);
      check("reset_pc", bus.out_pc, 32'h0);
      check("reset_inst", bus.out_inst, 32'h0);
      check("reset_misal", 32'(bus.redirect_misal), 32'd0);
      check("reset_addr", bus.imem_addr, 32'h0);

      // Release and stream: first word visible after the 2nd posedge
      rst = 1'b1;
      cycle(1'b1, 1'b0, '0);
      check("first_edge_valid", 32'(bus.out_valid), 32'd0);
      check("first_edge_addr", bus.imem_addr, 32'h1);
      cycle(1'b1, 1'b0, '0);
      check("second_edge_valid", 32'(bus.out_valid), 32'd1);
      check("second_edge_pc", bus.out_pc, 32'h0);
      check("second_edge_inst", bus.out_inst, 32'h1000_0000);
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 1'b0, '0);
         check("stream_throughput", 32'(bus.out_valid), 32'd1);
      end
      check("stall_start_pc", bus.out_pc, 32'h8);

      // Stall for 5 cycles with head at PC 8
      cycle(1'b0, 1'b0, '0);
      addr_snap = bus.imem_addr;
      repeat (4) cycle(1'b0, 1'b0, '0);
      check("stall_addr_frozen", bus.imem_addr, addr_snap);
      check("stall_count", 32'(dut.fifo_count), 32'd2);
      check("stall_head_pc", bus.out_pc, 32'h8);
      repeat (3) cycle(1'b1, 1'b0, '0);
      check("post_stall_head", bus.out_pc, 32'h14);

      // Redirect while the buffer is full
      repeat (3) cycle(1'b0, 1'b0, '0);
      check("full_before_redirect", 32'(dut.fifo_count), 32'd2);
      cycle(1'b0, 1'b1, 32'h40);
      check("redirect_addr", bus.imem_addr, 32'h10);
      cycle(1'b0, 1'b0, '0);
      check("redirect_n1_valid", 32'(bus.out_valid), 32'd0);
      cycle(1'b0, 1'b0, '0);
      check("redirect_n2_valid", 32'(bus.out_valid), 32'd1);
      check("redirect_n2_pc", bus.out_pc, 32'h40);
      repeat (3) cycle(1'b1, 1'b0, '0);

      // Redirect colliding with a pop
      check("collide_head_valid", 32'(bus.out_valid), 32'd1);
      cycle(1'b1, 1'b1, 32'h80);
      cycle(1'b1, 1'b0, '0);
      cycle(1'b1, 1'b0, '0);
      check("collide_target_pc", bus.out_pc, 32'h80);
      repeat (2) cycle(1'b1, 1'b0, '0);

      // Misaligned redirect
      cycle(1'b1, 1'b1, 32'h52);
      check("misal_set", 32'(bus.redirect_misal), 32'd1);
      cycle(1'b1, 1'b0, '0);
      check("misal_clear", 32'(bus.redirect_misal), 32'd0);
      cycle(1'b1, 1'b0, '0);
      check("misal_target_pc", bus.out_pc, 32'h50);
      repeat (2) cycle(1'b1, 1'b0, '0);

      // PC wrap at the top of the address space
      cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
      cycle(1'b1, 1'b0, '0);
      cycle(1'b1, 1'b0, '0);
      check("wrap_top_pc", bus.out_pc, 32'hFFFF_FFFC);
      cycle(1'b1, 1'b0, '0);
      check("wrap_zero_pc", bus.out_pc, 32'h0);
      check("wrap_zero_inst", bus.out_inst, 32'h1000_0000);
      repeat (2) cycle(1'b1, 1'b0, '0);

      // Random traffic: backpressure and occasional redirects
      for (int i = 0; i < 400; i++) begin
         logic    rdy;
         logic    rv;
         rvword_t rpc;
         rdy = ($urandom_range(0, 9) < 7);
         rv  = ($urandom_range(0, 19) == 0);
         rpc = $urandom;
         cycle(rdy, rv, rpc);
      end

      // Asynchronous reset mid-stream
      repeat (4) cycle(1'b1, 1'b0, '0);
      check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
      #3 rst = 1'b0;
      #1;
      check("async_reset_valid", 32'(bus.out_valid), 32'd0);
      check("async_reset_addr", bus.imem_addr, 32'h0);
      check("async_reset_pc", bus.out_pc, 32'h0);
      check("async_reset_inst", bus.out_inst, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("held_reset_valid", 32'(bus.out_valid), 32'd0);
      rst    = 1'b1;
      exp_pc = '0;
      idle   = 0;
      cycle(1'b1, 1'b0, '0);
      check("restart_first_edge_valid", 32'(bus.out_valid), 32'd0);
      cycle(1'b1, 1'b0, '0);
      check("restart_second_edge_valid", 32'(bus.out_valid), 32'd1);
      check("restart_second_edge_pc", bus.out_pc, 32'h0);
      repeat (4) cycle(1'b1, 1'b0, '0);
      check("restart_stream_pc", bus.out_pc, 32'h10);

      check("delivered_min", 32'(delivered > 100), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
